face_seq_ctrl: RTL and testbench
================================

// Module: face_seq_ctrl
// PURPOSE
//  Initiator/sequencer for the face-recognition datapath top: drives its enables, clears, iterators and data_in.
//  Takes one valid/ready word stream (mean, eigenvectors, face), runs projection and match, returns the result word.
//  Sits between the host/DMA stream and the datapath top; the datapath is a passive register/compute slave.
// PARAMETERS
//  NUM_PIXELS   161  words per mean/face vector and per eigen column
//  COLS_SIZE    8    eigen columns
//  NUM_WEIGHTS  400  projection weight slots (sizes weight_iter)
//  NUM_SAMPLES  400  training samples matched (sizes sample_iter)
//  TIMEOUT_CYC  4096 match watchdog limit (used only with FACE_SEQ_TIMEOUT_EN)
// PORTS
//  clk              in   1   clock (one clock)
//  rst              in   1   reset, synchronous, active-high
//  start            in   1   begin a run; sampled in IDLE only
//  in_valid         in   1   stream word valid
//  in_ready         out  1   stream word accepted when in_valid&&in_ready
//  in_data          in   32  stream word
//  res_valid        out  1   result held valid until res_ready
//  res_ready        in   1   result consumer ready
//  res_data         out  32  match result (captured datapath data_out)
//  res_err          out  1   1 = watchdog expired (0 without FACE_SEQ_TIMEOUT_EN)
//  busy             out  1   high in every state except IDLE
//  dp_data          out  32  to datapath data_in
//  dp_en_mean/face/p/r/out  out 1 each  datapath enables
//  dp_clr_m/f/p/r/out       out 1 each  datapath clears
//  dp_pixel_iter    out  16  dp_eigen_iter out 4  dp_weight_iter out 9  dp_sample_iter out 9
//  dp_done          in   1   datapath done_flg
//  dp_result        in   32  datapath data_out
// BEHAVIOUR
//  Reset: state IDLE; every output 0 (in_ready, res_valid, res_err, busy, all dp_*). Reset mid-run aborts at once.
//  All dp_* outputs registered: word accepted in cycle N -> dp_data=word, enable and iterator valid in cycle N+1 for 1 cycle.
//  FSM: IDLE -start-> CLEAR -> LD_MEAN -> LD_EIG -> LD_FACE -> PROJ -> MATCH -> RESULT -> IDLE.
//  IDLE: in_ready=0; start while busy is ignored (no queuing).
//  CLEAR: exactly 1 cycle, all five dp_clr_* =1; counters zeroed.
//  LD_MEAN: in_ready=1; NUM_PIXELS words, pixel_iter 0..NUM_PIXELS-1, dp_en_mean per word.
//  LD_EIG: COLS_SIZE*NUM_PIXELS words; pixel_iter inner (0..NUM_PIXELS-1), eigen_iter outer (0..COLS_SIZE-1); dp_en_p.
//  LD_FACE: NUM_PIXELS words, dp_en_face, pixel_iter as LD_MEAN.
//  in_valid gaps stall the count; no enable pulses during gaps. in_ready drops the cycle after the last word of LD_FACE.
//  Last-word transitions: in_ready stays 1 across LD_MEAN->LD_EIG->LD_FACE boundaries (no bubble).
//  PROJ: in_ready=0; dp_en_r=1 for COLS_SIZE*NUM_PIXELS cycles; weight_iter=column 0..COLS_SIZE-1 outer, pixel_iter inner.
//  MATCH: dp_en_out=1, sample_iter increments 0..NUM_SAMPLES-1 then holds; leave on first cycle dp_done=1.
//  RESULT: dp_result captured into res_data on dp_done cycle; res_valid=1 until res_valid&&res_ready, then IDLE next cycle.
//  res_data/res_err stable while res_valid=1. Iterators hold last value when their enable is low.
//  Counter wrap: pixel counter wraps to 0 at NUM_PIXELS-1 and increments eigen/weight; no counter exceeds its bound.
// CONFIGURATION
//  FACE_SEQ_TIMEOUT_EN defined: MATCH counts cycles; if TIMEOUT_CYC reached without dp_done -> RESULT, res_err=1, res_data=0.
//  dp_done on the same cycle as expiry wins (res_err=0).
//  Undefined: no watchdog, MATCH waits indefinitely, res_err tied 0.
// STRUCTURE
//  face_seq_pkg: state enum (IDLE..RESULT), iterator width localparams, default-param constants.
//  Sub-module nested_iter_cnt: inner/outer counter with step, inner_last, all_last; reused by LD_EIG and PROJ.
// TESTING
//  Reset mid-LD_EIG (word 500) -> next cycle all outputs 0, state IDLE; new start runs cleanly.
//  Full run, in_valid always 1 -> CLEAR 1 cycle; 161 en_mean, 1288 en_p, 161 en_face pulses; in_ready high 1610 consecutive cycles.
//  in_valid toggling every other cycle -> same pulse counts, eigen_iter 0->7 stepping after pixel_iter=160.
//  dp_done after 37 MATCH cycles with dp_result=32'h0000_002A -> res_data=32'h2A, res_err=0, held while res_ready=0.
//  start pulsed during PROJ -> ignored; single run completes.
//  With FACE_SEQ_TIMEOUT_EN, TIMEOUT_CYC=16, dp_done never -> res_err=1, res_data=0 after 16 MATCH cycles.

Source files
------------

// File: rtl/face_seq_pkg.sv
// face_seq_pkg: shared definitions for the face-recognition sequencer.
//  - state_t: sequencer states, IDLE through RESULT
//  - *_ITER_W: widths of the datapath iterator buses and the data word
//  - DEF_*: default sizing constants for the sequencer parameters
// DEF_TIMEOUT_CYC exists only when FACE_SEQ_TIMEOUT_EN is defined.
package face_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LD_MEAN,
    S_LD_EIG,
    S_LD_FACE,
    S_PROJ,
    S_MATCH,
    S_RESULT
  } state_t;

  localparam int DATA_W        = 32;
  localparam int PIXEL_ITER_W  = 16;
  localparam int EIGEN_ITER_W  = 4;
  localparam int WEIGHT_ITER_W = 9;
  localparam int SAMPLE_ITER_W = 9;

  localparam int DEF_NUM_PIXELS  = 161;
  localparam int DEF_COLS_SIZE   = 8;
  localparam int DEF_NUM_WEIGHTS = 400;
  localparam int DEF_NUM_SAMPLES = 400;

`ifdef FACE_SEQ_TIMEOUT_EN
  // Only the watchdog build has a MATCH cycle limit.
  localparam int DEF_TIMEOUT_CYC = 4096;
`endif

endpackage

// File: rtl/face_seq_ctrl_nested_iter_cnt.sv
// nested_iter_cnt: two-level counter. The inner index runs 0..INNER_MAX and
// the outer index advances once per inner wrap, wrapping after OUTER_MAX.
// Ports:
//  clk, rst     clock and synchronous active-high reset
//  clr          zero both indices (takes priority over step)
//  step         advance by one position
//  inner/outer  current indices
//  inner_last   inner index is at INNER_MAX
//  all_last     both indices at their maximum (final position)
module nested_iter_cnt
  import face_seq_pkg::*;
#(
  parameter int INNER_W   = PIXEL_ITER_W,
  parameter int OUTER_W   = EIGEN_ITER_W,
  parameter int INNER_MAX = DEF_NUM_PIXELS - 1,
  parameter int OUTER_MAX = DEF_COLS_SIZE - 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               step,
  output logic [INNER_W-1:0] inner,
  output logic [OUTER_W-1:0] outer,
  output logic               inner_last,
  output logic               all_last
);

  localparam logic [INNER_W-1:0] INNER_END = INNER_W'(INNER_MAX);
  localparam logic [OUTER_W-1:0] OUTER_END = OUTER_W'(OUTER_MAX);

  assign inner_last = (inner == INNER_END);
  assign all_last   = inner_last && (outer == OUTER_END);

  // Neither index ever passes its bound: both wrap to 0 at the end of a sweep.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      inner <= '0;
      outer <= '0;
    end else if (step) begin
      if (inner_last) begin
        inner <= '0;
        outer <= (outer == OUTER_END) ? '0 : outer + 1'b1;
      end else begin
        inner <= inner + 1'b1;
      end
    end
  end

endmodule

// File: rtl/face_seq_ctrl.sv
// face_seq_ctrl: sequencer that drives the face-recognition datapath.
// It loads mean, eigenvector and face words from one valid/ready stream,
// runs projection, then runs match, and returns the result word.
// Ports:
//  clk, rst                  clock and synchronous active-high reset
//  start                     begin a run (looked at only while idle)
//  in_valid/in_ready/in_data word stream input
//  res_valid/res_ready       result handshake; res_data/res_err are held while valid
//  busy                      high whenever not idle
//  dp_*                      registered datapath data, enables, clears and iterators
//  dp_done, dp_result        datapath done flag and data_out
// Optional feature: define FACE_SEQ_TIMEOUT_EN to add a MATCH watchdog.
//  When it expires, the run finishes with res_err=1 and res_data=0.
module face_seq_ctrl
  import face_seq_pkg::*;
#(
  parameter int NUM_PIXELS  = DEF_NUM_PIXELS,
  parameter int COLS_SIZE   = DEF_COLS_SIZE,
  parameter int NUM_WEIGHTS = DEF_NUM_WEIGHTS,
  parameter int NUM_SAMPLES = DEF_NUM_SAMPLES
`ifdef FACE_SEQ_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
  output logic                     res_err,
  output logic                     busy,
  output logic [DATA_W-1:0]        dp_data,
  output logic                     dp_en_mean,
  output logic                     dp_en_face,
  output logic                     dp_en_p,
  output logic                     dp_en_r,
  output logic                     dp_en_out,
  output logic                     dp_clr_m,
  output logic                     dp_clr_f,
  output logic                     dp_clr_p,
  output logic                     dp_clr_r,
  output logic                     dp_clr_out,
  output logic [PIXEL_ITER_W-1:0]  dp_pixel_iter,
  output logic [EIGEN_ITER_W-1:0]  dp_eigen_iter,
  output logic [WEIGHT_ITER_W-1:0] dp_weight_iter,
  output logic [SAMPLE_ITER_W-1:0] dp_sample_iter,
  input  logic                     dp_done,
  input  logic [DATA_W-1:0]        dp_result
);

  localparam logic [SAMPLE_ITER_W-1:0] SAMPLE_END = SAMPLE_ITER_W'(NUM_SAMPLES - 1);
  localparam logic [WEIGHT_ITER_W-1:0] WEIGHT_END = WEIGHT_ITER_W'(NUM_WEIGHTS - 1);

  state_t state, state_nx;

  logic [PIXEL_ITER_W-1:0]  pix;
  logic [EIGEN_ITER_W-1:0]  col;
  logic                     inner_last, all_last;
  logic                     cnt_clr, cnt_step;
  logic [SAMPLE_ITER_W-1:0] sample_cnt;
  logic [WEIGHT_ITER_W-1:0] col_wide, weight_idx;
  logic                     clr_pulse;
  logic                     match_exit;

`ifdef FACE_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYC) + 1;
  localparam logic [WD_W-1:0] WD_END = WD_W'(TIMEOUT_CYC - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            match_err;
`endif

  // One pixel/column counter serves every phase. The mean and face loads use
  // only the inner index; the counter is cleared when they end so that the
  // next phase starts at (0,0).
  nested_iter_cnt #(
    .INNER_W  (PIXEL_ITER_W),
    .OUTER_W  (EIGEN_ITER_W),
    .INNER_MAX(NUM_PIXELS - 1),
    .OUTER_MAX(COLS_SIZE - 1)
  ) u_pix_col (
    .clk       (clk),
    .rst       (rst),
    .clr       (cnt_clr),
    .step      (cnt_step),
    .inner     (pix),
    .outer     (col),
    .inner_last(inner_last),
    .all_last  (all_last)
  );

  assign busy      = (state != S_IDLE);
  assign res_valid = (state == S_RESULT);
  assign clr_pulse = (state == S_IDLE) && start;
  assign col_wide  = WEIGHT_ITER_W'(col);
  assign weight_idx = (col_wide > WEIGHT_END) ? WEIGHT_END : col_wide;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // Next state, stream ready and counter control. In the load states
  // in_ready is 1, so in_valid alone marks an accepted word.
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    cnt_clr    = 1'b0;
    cnt_step   = 1'b0;
    match_exit = 1'b0;
`ifdef FACE_SEQ_TIMEOUT_EN
    match_err  = 1'b0;
`endif
    case (state)
      S_IDLE:    if (start) state_nx = S_CLEAR;
      S_CLEAR: begin
        cnt_clr  = 1'b1;
        state_nx = S_LD_MEAN;
      end
      S_LD_MEAN: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_step = 1'b1;
          if (inner_last) begin
            cnt_clr  = 1'b1;
            state_nx = S_LD_EIG;
          end
        end
      end
      S_LD_EIG: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_step = 1'b1;
          if (all_last) state_nx = S_LD_FACE;
        end
      end
      S_LD_FACE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          cnt_step = 1'b1;
          if (inner_last) begin
            cnt_clr  = 1'b1;
            state_nx = S_PROJ;
          end
        end
      end
      S_PROJ: begin
        cnt_step = 1'b1;
        if (all_last) state_nx = S_MATCH;
      end
      S_MATCH: begin
        // If dp_done and watchdog expiry happen together, dp_done wins.
        if (dp_done) begin
          match_exit = 1'b1;
          state_nx   = S_RESULT;
        end
`ifdef FACE_SEQ_TIMEOUT_EN
        else if (wd_cnt == WD_END) begin
          match_exit = 1'b1;
          match_err  = 1'b1;
          state_nx   = S_RESULT;
        end
`endif
      end
      S_RESULT:  if (res_ready) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Match sample index: starts at 0 for each run, then counts up to the
  // last sample and stays there.
  always_ff @(posedge clk) begin
    if (rst || state == S_CLEAR)
      sample_cnt <= '0;
    else if (state == S_MATCH && sample_cnt != SAMPLE_END)
      sample_cnt <= sample_cnt + 1'b1;
  end

`ifdef FACE_SEQ_TIMEOUT_EN
  // Watchdog: counts MATCH cycles in the current run.
  always_ff @(posedge clk) begin
    if (rst || state == S_CLEAR)  wd_cnt <= '0;
    else if (state == S_MATCH)    wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign res_err = 1'b0;
`endif

  // Registered datapath outputs. Enables and clears are one-cycle pulses.
  // Data and iterators change only with a pulse and otherwise hold.
  // The clears are registered from the start request, so they are high
  // during the CLEAR cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_data        <= '0;
      dp_en_mean     <= 1'b0;
      dp_en_face     <= 1'b0;
      dp_en_p        <= 1'b0;
      dp_en_r        <= 1'b0;
      dp_en_out      <= 1'b0;
      dp_clr_m       <= 1'b0;
      dp_clr_f       <= 1'b0;
      dp_clr_p       <= 1'b0;
      dp_clr_r       <= 1'b0;
      dp_clr_out     <= 1'b0;
      dp_pixel_iter  <= '0;
      dp_eigen_iter  <= '0;
      dp_weight_iter <= '0;
      dp_sample_iter <= '0;
      res_data       <= '0;
`ifdef FACE_SEQ_TIMEOUT_EN
      res_err        <= 1'b0;
`endif
    end else begin
      dp_en_mean <= 1'b0;
      dp_en_face <= 1'b0;
      dp_en_p    <= 1'b0;
      dp_en_r    <= 1'b0;
      dp_en_out  <= 1'b0;
      dp_clr_m   <= clr_pulse;
      dp_clr_f   <= clr_pulse;
      dp_clr_p   <= clr_pulse;
      dp_clr_r   <= clr_pulse;
      dp_clr_out <= clr_pulse;
      case (state)
        S_LD_MEAN: if (in_valid) begin
          dp_data       <= in_data;
          dp_en_mean    <= 1'b1;
          dp_pixel_iter <= pix;
        end
        S_LD_EIG: if (in_valid) begin
          dp_data       <= in_data;
          dp_en_p       <= 1'b1;
          dp_pixel_iter <= pix;
          dp_eigen_iter <= col;
        end
        S_LD_FACE: if (in_valid) begin
          dp_data       <= in_data;
          dp_en_face    <= 1'b1;
          dp_pixel_iter <= pix;
        end
        S_PROJ: begin
          dp_en_r        <= 1'b1;
          dp_pixel_iter  <= pix;
          dp_weight_iter <= weight_idx;
        end
        S_MATCH: begin
          dp_en_out      <= 1'b1;
          dp_sample_iter <= sample_cnt;
          if (match_exit) begin
`ifdef FACE_SEQ_TIMEOUT_EN
            res_data <= match_err ? '0 : dp_result;
            res_err  <= match_err;
`else
            res_data <= dp_result;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_face_seq_ctrl.sv
// tb_face_seq_ctrl: randomized self-checking bench for face_seq_ctrl.
// The reference model describes a run as counts: words loaded, projection
// cycles and match cycles. Expected outputs are derived from those counts.
// Per-run pulse totals are also compared with fixed literal values.
module tb_face_seq_ctrl;

  localparam int NP         = 161;
  localparam int CS         = 8;
  localparam int NS         = 400;
  localparam int NW         = 400;
  localparam int EIG_END    = NP * (CS + 1);
  localparam int LOAD_WORDS = NP * (CS + 2);
  localparam int PROJ_CYC   = NP * CS;
  localparam int RUN_BUDGET = 20000;
`ifdef FACE_SEQ_TIMEOUT_EN
  localparam int TO = 16;
`endif

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, res_valid, res_ready, res_err, busy;
  logic [31:0] in_data, res_data, dp_data, dp_result;
  logic        dp_en_mean, dp_en_face, dp_en_p, dp_en_r, dp_en_out;
  logic        dp_clr_m, dp_clr_f, dp_clr_p, dp_clr_r, dp_clr_out, dp_done;
  logic [15:0] dp_pixel_iter;
  logic [3:0]  dp_eigen_iter;
  logic [8:0]  dp_weight_iter, dp_sample_iter;

  always #5 clk = ~clk;

  face_seq_ctrl #(
    .NUM_PIXELS (NP),
    .COLS_SIZE  (CS),
    .NUM_WEIGHTS(NW),
    .NUM_SAMPLES(NS)
`ifdef FACE_SEQ_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(TO)
`endif
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err),
    .busy(busy), .dp_data(dp_data),
    .dp_en_mean(dp_en_mean), .dp_en_face(dp_en_face), .dp_en_p(dp_en_p),
    .dp_en_r(dp_en_r), .dp_en_out(dp_en_out),
    .dp_clr_m(dp_clr_m), .dp_clr_f(dp_clr_f), .dp_clr_p(dp_clr_p),
    .dp_clr_r(dp_clr_r), .dp_clr_out(dp_clr_out),
    .dp_pixel_iter(dp_pixel_iter), .dp_eigen_iter(dp_eigen_iter),
    .dp_weight_iter(dp_weight_iter), .dp_sample_iter(dp_sample_iter),
    .dp_done(dp_done), .dp_result(dp_result)
  );

  typedef enum {M_IDLE, M_CLEAR, M_LOAD, M_PROJ, M_MATCH, M_RESULT} mphase_t;

  int tests = 0;
  int failures = 0;

  // Model state: the current phase and how far each phase has progressed.
  mphase_t ph;
  int k, p, m, rcnt;
  logic [31:0] e_data, e_res_data;
  bit e_en_mean, e_en_face, e_en_p, e_en_r, e_en_out, e_clr, e_res_err;
  int e_pix, e_eig, e_wt, e_smp;

  // Settings for the current run.
  int vmode, done_at, abort_at, rdy_hold, idle_gap, idle_cnt;
  bit force2a, started, tog, rst_prev;

  // Per-run statistics observed on the DUT.
  int n_mean, n_face, n_p, n_r, n_out, n_clr, n_rv, streak, max_streak, max_eig, max_smp;
  bit got_res, obs_err;
  logic [31:0] obs_res;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task modelReset();
    ph = M_IDLE; k = 0; p = 0; m = 0; rcnt = 0;
    e_data = '0; e_res_data = '0; e_res_err = 1'b0;
    e_en_mean = 0; e_en_face = 0; e_en_p = 0; e_en_r = 0; e_en_out = 0; e_clr = 0;
    e_pix = 0; e_eig = 0; e_wt = 0; e_smp = 0;
  endtask

  // Advance the model by one clock edge, using the inputs that were just
  // applied.
  task modelStep();
    if (rst) begin
      modelReset();
    end else begin
      e_en_mean = 0; e_en_face = 0; e_en_p = 0; e_en_r = 0; e_en_out = 0; e_clr = 0;
      case (ph)
        M_IDLE: if (start) begin ph = M_CLEAR; e_clr = 1; end
        M_CLEAR: begin ph = M_LOAD; k = 0; end
        M_LOAD: if (in_valid) begin
          e_data = in_data;
          if (k < NP) begin
            e_en_mean = 1; e_pix = k;
          end else if (k < EIG_END) begin
            e_en_p = 1; e_pix = (k - NP) % NP; e_eig = (k - NP) / NP;
          end else begin
            e_en_face = 1; e_pix = k - EIG_END;
          end
          k++;
          if (k == LOAD_WORDS) begin ph = M_PROJ; p = 0; end
        end
        M_PROJ: begin
          e_en_r = 1; e_pix = p % NP; e_wt = p / NP;
          p++;
          if (p == PROJ_CYC) begin ph = M_MATCH; m = 0; end
        end
        M_MATCH: begin
          e_en_out = 1;
          e_smp = (m < NS - 1) ? m : NS - 1;
          if (dp_done) begin
            e_res_data = dp_result; e_res_err = 0; ph = M_RESULT; rcnt = 0;
          end
`ifdef FACE_SEQ_TIMEOUT_EN
          else if (m == TO - 1) begin
            e_res_data = '0; e_res_err = 1; ph = M_RESULT; rcnt = 0;
          end
`endif
          m++;
        end
        M_RESULT: begin
          if (res_ready) ph = M_IDLE;
          rcnt++;
        end
        default: ph = M_IDLE;
      endcase
    end
  endtask

  task applyStimulus();
    rst = 1'b0;
    case (vmode)
      0:       in_valid = 1'b1;
      1:       begin in_valid = tog; tog = ~tog; end
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    in_data   = $urandom();
    dp_result = force2a ? 32'h0000_002A : $urandom();
    dp_done   = (ph == M_MATCH) && (m == done_at);
    res_ready = (ph == M_RESULT) ? (rcnt >= rdy_hold) : 1'($urandom_range(0, 1));
    if (ph == M_IDLE) begin
      start = !started && (idle_cnt >= idle_gap);
      if (start) started = 1'b1;
      idle_cnt++;
    end else begin
      start = ($urandom_range(0, 15) == 0);
    end
    if (abort_at >= 0 && ph == M_LOAD && k == abort_at) begin
      rst = 1'b1; start = 1'b0; abort_at = -1;
    end
    rst_prev = rst;
  endtask

  task checkOutput();
    check("in_ready", 32'(in_ready), 32'(ph == M_LOAD));
    check("busy", 32'(busy), 32'(ph != M_IDLE));
    check("res_valid", 32'(res_valid), 32'(ph == M_RESULT));
    check("res_data", res_data, e_res_data);
    check("res_err", 32'(res_err), 32'(e_res_err));
    check("dp_data", dp_data, e_data);
    check("dp_en_mean", 32'(dp_en_mean), 32'(e_en_mean));
    check("dp_en_face", 32'(dp_en_face), 32'(e_en_face));
    check("dp_en_p", 32'(dp_en_p), 32'(e_en_p));
    check("dp_en_r", 32'(dp_en_r), 32'(e_en_r));
    check("dp_en_out", 32'(dp_en_out), 32'(e_en_out));
    check("dp_clr", 32'({dp_clr_m, dp_clr_f, dp_clr_p, dp_clr_r, dp_clr_out}), 32'({5{e_clr}}));
    check("pixel_iter", 32'(dp_pixel_iter), 32'(e_pix));
    check("eigen_iter", 32'(dp_eigen_iter), 32'(e_eig));
    check("weight_iter", 32'(dp_weight_iter), 32'(e_wt));
    check("sample_iter", 32'(dp_sample_iter), 32'(e_smp));
    if (rst_prev) begin
      check("reset_in_ready", 32'(in_ready), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_en_p", 32'(dp_en_p), 32'd0);
      check("reset_pixel_iter", 32'(dp_pixel_iter), 32'd0);
    end
    n_mean += int'(dp_en_mean); n_face += int'(dp_en_face); n_p += int'(dp_en_p);
    n_r += int'(dp_en_r); n_out += int'(dp_en_out); n_clr += int'(dp_clr_m);
    n_rv += int'(res_valid);
    streak = in_ready ? streak + 1 : 0;
    if (streak > max_streak) max_streak = streak;
    if (int'(dp_eigen_iter) > max_eig) max_eig = int'(dp_eigen_iter);
    if (int'(dp_sample_iter) > max_smp) max_smp = int'(dp_sample_iter);
    if (res_valid && !got_res) begin got_res = 1; obs_res = res_data; obs_err = res_err; end
  endtask

  task runCycle();
    @(negedge clk);
    checkOutput();
    applyStimulus();
    modelStep();
  endtask

  task runOne(input int vm, input int dn, input int ab, input int hold, input bit f2a);
    int cyc;
    bit aborted;
    vmode = vm; done_at = dn; abort_at = ab; rdy_hold = hold; force2a = f2a;
    idle_gap = $urandom_range(0, 3); idle_cnt = 0; started = 0; tog = 1;
    n_mean = 0; n_face = 0; n_p = 0; n_r = 0; n_out = 0; n_clr = 0; n_rv = 0;
    streak = 0; max_streak = 0; max_eig = 0; max_smp = 0; got_res = 0;
    aborted = (ab >= 0);
    cyc = 0;
    while (!(started && ph == M_IDLE)) begin
      runCycle();
      cyc++;
      if (cyc > RUN_BUDGET) begin
        tests++; failures++;
        $display("[TB] FAIL run_budget: got %0d cycles, expected at most %0d", cyc, RUN_BUDGET);
        break;
      end
    end
    if (!aborted) begin
      check("n_en_mean", 32'(n_mean), 32'd161);
      check("n_en_p", 32'(n_p), 32'd1288);
      check("n_en_face", 32'(n_face), 32'd161);
      check("n_en_r", 32'(n_r), 32'd1288);
      check("n_clr_cycles", 32'(n_clr), 32'd1);
      check("n_en_out", 32'(n_out), 32'(m));
      check("max_eigen_iter", 32'(max_eig), 32'd7);
      check("res_seen", 32'(got_res), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 0; in_valid = 0; in_data = '0; res_ready = 0;
    dp_done = 0; dp_result = '0; rst_prev = 1;
    vmode = 0; done_at = -1; abort_at = -1; rdy_hold = 0; force2a = 0;
    modelReset();
    @(negedge clk);

    // Reset after 500 words, which is inside the eigenvector load.
    runOne(2, 10, 500, 0, 0);

    // in_valid always high; dp_done after 37 match cycles; res_ready held low.
    runOne(0, 37, -1, 6, 1);
    check("ready_streak", 32'(max_streak), 32'd1610);
`ifndef FACE_SEQ_TIMEOUT_EN
    check("result_2a", obs_res, 32'h0000_002A);
    check("result_err", 32'(obs_err), 32'd0);
    check("result_hold_cycles", 32'(n_rv), 32'd7);
`endif

    // in_valid high every other cycle.
    runOne(1, $urandom_range(1, 60), -1, $urandom_range(0, 4), 0);

    // Long match: the sample iterator must stop at its last index.
    runOne(2, 420, -1, 1, 0);
`ifndef FACE_SEQ_TIMEOUT_EN
    check("sample_hold", 32'(max_smp), 32'd399);
`endif

    // dp_done on the very first match cycle.
    runOne(2, 0, -1, $urandom_range(0, 3), 0);

`ifdef FACE_SEQ_TIMEOUT_EN
    // dp_done never arrives: the watchdog ends the run.
    runOne(0, -1, -1, 2, 0);
    check("timeout_err", 32'(obs_err), 32'd1);
    check("timeout_data", obs_res, 32'd0);
    check("timeout_cycles", 32'(n_out), 32'd16);
    // dp_done in the same cycle as expiry: dp_done wins.
    runOne(2, TO - 1, -1, 1, 1);
    check("done_wins_err", 32'(obs_err), 32'd0);
`endif

    runCycle();
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
